// File: rtl/exec_writeback_seq_pkg.sv
// -----------------------------------------------------------------------------
// exec_writeback_seq_pkg
// Shared definitions for the execute back end:
//   - functype codes (also used by the operand picker)
//   - default geometry: ELEMS vector elements of EW bits, AW-bit addresses
//   - writeback sequencer state encoding
// -----------------------------------------------------------------------------
package exec_writeback_seq_pkg;

  localparam int DEF_ELEMS = 16;
  localparam int DEF_EW    = 16;
  localparam int DEF_AW    = 16;

  localparam logic [3:0] FT_VADD = 4'b0000;
  localparam logic [3:0] FT_VDOT = 4'b0001;
  localparam logic [3:0] FT_SMUL = 4'b0010;
  localparam logic [3:0] FT_SST  = 4'b0011;
  localparam logic [3:0] FT_VLD  = 4'b0100;
  localparam logic [3:0] FT_VST  = 4'b0101;
  localparam logic [3:0] FT_SLL  = 4'b0110;
  localparam logic [3:0] FT_SLH  = 4'b0111;
  localparam logic [3:0] FT_J    = 4'b1000;
  localparam logic [3:0] FT_NOP  = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SINGLE   = 3'd1,
    ST_VST_XFER = 3'd2,
    ST_VLD_XFER = 3'd3,
    ST_VLD_WB   = 3'd4
  } state_e;

endpackage

// File: rtl/exec_writeback_seq.sv
// -----------------------------------------------------------------------------
// exec_writeback_seq
// Retires one executed instruction: vector/scalar register writes, PC load,
// scalar store, and the element-serial VST/VLD memory transfers.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   start                       accept pulse (honoured only when idle)
//   functype, result            instruction code and execute output
//   store_vec, store_scalar     store data for VST / SST
//   vd, rd                      destination vector / scalar register
//   mem_rdata                   memory read data, one cycle after mem_re
//   busy, done                  in-progress flag, final-cycle pulse
//   vwe/vwaddr/vwdata           vector register file write port
//   swe/swaddr/swdata           scalar register file write port
//   pc_load/pc_next             PC load port
//   mem_addr/mem_wdata/mem_we/mem_re   memory port
//
// All strobes, addresses and data are registered. Address/data outputs keep
// their last value while their strobe is low.
// -----------------------------------------------------------------------------
module exec_writeback_seq
  import exec_writeback_seq_pkg::*;
#(
  parameter int ELEMS = DEF_ELEMS,
  parameter int EW    = DEF_EW,
  parameter int AW    = DEF_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          functype,
  input  logic [ELEMS*EW-1:0] result,
  input  logic [ELEMS*EW-1:0] store_vec,
  input  logic [EW-1:0]       store_scalar,
  input  logic [2:0]          vd,
  input  logic [2:0]          rd,
  input  logic [EW-1:0]       mem_rdata,
  output logic                busy,
  output logic                done,
  output logic                vwe,
  output logic [2:0]          vwaddr,
  output logic [ELEMS*EW-1:0] vwdata,
  output logic                swe,
  output logic [2:0]          swaddr,
  output logic [EW-1:0]       swdata,
  output logic                pc_load,
  output logic [AW-1:0]       pc_next,
  output logic [AW-1:0]       mem_addr,
  output logic [EW-1:0]       mem_wdata,
  output logic                mem_we,
  output logic                mem_re
);

  localparam int VW = ELEMS * EW;
  localparam int CW = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ELEMS - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      vd_q, vd_d;
  logic [VW-1:0]   store_vec_q, store_vec_d;
  logic [VW-1:0]   vld_buf_q, vld_buf_d;
  logic            done_q, done_d;
  logic            vwe_q, vwe_d;
  logic [2:0]      vwaddr_q, vwaddr_d;
  logic [VW-1:0]   vwdata_q, vwdata_d;
  logic            swe_q, swe_d;
  logic [2:0]      swaddr_q, swaddr_d;
  logic [EW-1:0]   swdata_q, swdata_d;
  logic            pc_load_q, pc_load_d;
  logic [AW-1:0]   pc_next_q, pc_next_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [EW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            mem_we_q, mem_we_d;
  logic            mem_re_q, mem_re_d;

  logic [CW-1:0]   cnt_inc;
  logic [VW-1:0]   vld_shift;

  assign cnt_inc = cnt_q + CW'(1);
  // Read data enters at the top and shifts down, so after ELEMS samples the
  // first element read (lowest address) sits in the low bits.
  assign vld_shift = {mem_rdata, vld_buf_q[VW-1:EW]};

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves one
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    vd_d        = vd_q;
    store_vec_d = store_vec_q;
    vld_buf_d   = vld_buf_q;
    vwaddr_d    = vwaddr_q;
    vwdata_d    = vwdata_q;
    swaddr_d    = swaddr_q;
    swdata_d    = swdata_q;
    pc_next_d   = pc_next_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    // Strobes and done are single-cycle unless re-asserted below.
    done_d      = 1'b0;
    vwe_d       = 1'b0;
    swe_d       = 1'b0;
    pc_load_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Single-cycle ops consume result/store_scalar/rd straight into the
          // output registers; only what the multi-cycle ops need later is held.
          vd_d        = vd;
          store_vec_d = store_vec;
          cnt_d       = '0;
          state_d     = ST_SINGLE;
          done_d      = 1'b1;
          case (functype)
            FT_VADD, FT_SMUL: begin
              vwe_d    = 1'b1;
              vwaddr_d = vd;
              vwdata_d = result;
            end
            FT_VDOT, FT_SLL, FT_SLH: begin
              swe_d    = 1'b1;
              swaddr_d = rd;
              swdata_d = result[EW-1:0];
            end
            FT_J: begin
              pc_load_d = 1'b1;
              pc_next_d = result[AW-1:0];
            end
            FT_SST: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = result[AW-1:0];
              mem_wdata_d = store_scalar;
            end
            FT_VST: begin
              state_d     = ST_VST_XFER;
              done_d      = (ELEMS == 1);
              mem_we_d    = 1'b1;
              mem_addr_d  = result[AW-1:0];
              mem_wdata_d = store_vec[EW-1:0];
            end
            FT_VLD: begin
              state_d    = ST_VLD_XFER;
              done_d     = 1'b0;
              mem_re_d   = 1'b1;
              mem_addr_d = result[AW-1:0];
            end
            default: ;  // NOP and undefined codes: done only
          endcase
        end
      end

      ST_SINGLE: state_d = ST_IDLE;

      // cnt_q is the element whose write is on the port this cycle.
      ST_VST_XFER: begin
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d       = cnt_inc;
          mem_we_d    = 1'b1;
          mem_addr_d  = mem_addr_q + AW'(1);  // wraps modulo 2^AW
          mem_wdata_d = store_vec_q[EW*cnt_inc +: EW];
          done_d      = (cnt_inc == LAST);
        end
      end

      // cnt_q is the element whose read is issued this cycle; the data for
      // element cnt_q-1 is on mem_rdata now.
      ST_VLD_XFER: begin
        if (cnt_q != '0) vld_buf_d = vld_shift;
        if (cnt_q == LAST) begin
          state_d = ST_VLD_WB;
        end else begin
          cnt_d      = cnt_inc;
          mem_re_d   = 1'b1;
          mem_addr_d = mem_addr_q + AW'(1);
        end
      end

      // First VLD_WB cycle catches the last element and arms the write;
      // the second presents vwe/done, then the sequencer returns to idle.
      ST_VLD_WB: begin
        if (!done_q) begin
          vld_buf_d = vld_shift;
          vwe_d     = 1'b1;
          vwaddr_d  = vd_q;
          vwdata_d  = vld_shift;
          done_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      vd_q        <= '0;
      store_vec_q <= '0;
      vld_buf_q   <= '0;
      done_q      <= 1'b0;
      vwe_q       <= 1'b0;
      vwaddr_q    <= '0;
      vwdata_q    <= '0;
      swe_q       <= 1'b0;
      swaddr_q    <= '0;
      swdata_q    <= '0;
      pc_load_q   <= 1'b0;
      pc_next_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vd_q        <= vd_d;
      store_vec_q <= store_vec_d;
      vld_buf_q   <= vld_buf_d;
      done_q      <= done_d;
      vwe_q       <= vwe_d;
      vwaddr_q    <= vwaddr_d;
      vwdata_q    <= vwdata_d;
      swe_q       <= swe_d;
      swaddr_q    <= swaddr_d;
      swdata_q    <= swdata_d;
      pc_load_q   <= pc_load_d;
      pc_next_q   <= pc_next_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign vwe       = vwe_q;
  assign vwaddr    = vwaddr_q;
  assign vwdata    = vwdata_q;
  assign swe       = swe_q;
  assign swaddr    = swaddr_q;
  assign swdata    = swdata_q;
  assign pc_load   = pc_load_q;
  assign pc_next   = pc_next_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_exec_writeback_seq.sv
// -----------------------------------------------------------------------------
// tb_exec_writeback_seq
// Self-checking bench for exec_writeback_seq: a table of single-cycle ops,
// hand-written VST/VLD/reset sequences, and random instructions compared
// against an event-list reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_exec_writeback_seq;
  import exec_writeback_seq_pkg::*;

  localparam int ELEMS = 16;
  localparam int EW    = 16;
  localparam int AW    = 16;
  localparam int VW    = ELEMS * EW;
  localparam int CKW   = 320;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [3:0]      functype;
  logic [VW-1:0]   result;
  logic [VW-1:0]   store_vec;
  logic [EW-1:0]   store_scalar;
  logic [2:0]      vd;
  logic [2:0]      rd;
  logic [EW-1:0]   mem_rdata = '0;
  logic            busy, done, vwe, swe, pc_load, mem_we, mem_re;
  logic [2:0]      vwaddr, swaddr;
  logic [VW-1:0]   vwdata;
  logic [EW-1:0]   swdata, mem_wdata;
  logic [AW-1:0]   pc_next, mem_addr;

  exec_writeback_seq #(.ELEMS(ELEMS), .EW(EW), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .functype     (functype),
    .result       (result),
    .store_vec    (store_vec),
    .store_scalar (store_scalar),
    .vd           (vd),
    .rd           (rd),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .done         (done),
    .vwe          (vwe),
    .vwaddr       (vwaddr),
    .vwdata       (vwdata),
    .swe          (swe),
    .swaddr       (swaddr),
    .swdata       (swdata),
    .pc_load      (pc_load),
    .pc_next      (pc_next),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model: content is 0xA000+addr, returned the cycle after mem_re.
  // Outside a read the bus carries junk so mis-timed sampling shows up.
  function automatic logic [EW-1:0] mem_val(input logic [AW-1:0] a);
    return 16'hA000 + a;
  endfunction

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem_val(mem_addr);
    else        mem_rdata <= 16'($urandom);
  end

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [VW-1:0] data;
  } ev_t;

  typedef struct {
    logic [3:0]    ft;
    logic [VW-1:0] res;
    logic [EW-1:0] ss;
    logic [2:0]    vd;
    logic [2:0]    rd;
    logic [4:0]    exp_stb;    // {vwe, swe, pc_load, mem_we, mem_re}
    logic [2:0]    exp_waddr;
    logic [VW-1:0] exp_wdata;
    logic [AW-1:0] exp_addr;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [CKW-1:0] act, input logic [CKW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {vwe, swe, pc_load, mem_we, mem_re};
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic cmp_ev(input string tag, input ev_t got[$], input ev_t exp[$]);
    check($sformatf("%s count", tag), CKW'(got.size()), CKW'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s[%0d] {cyc,addr,data}", tag, i),
            {32'(got[i].cyc), got[i].addr, got[i].data},
            {32'(exp[i].cyc), exp[i].addr, exp[i].data});
  endtask

  task automatic scramble_inputs();
    functype     = 4'($urandom);
    result       = rand_vec();
    store_vec    = rand_vec();
    store_scalar = 16'($urandom);
    vd           = 3'($urandom);
    rd           = 3'($urandom);
  endtask

  // Issue one instruction from idle and compare every side effect, with the
  // cycle (relative to capture) it appeared in, against the model's list.
  task automatic run_op(input logic [3:0] ft, input logic [VW-1:0] res, input logic [VW-1:0] sv,
                        input logic [EW-1:0] ss, input logic [2:0] v, input logic [2:0] r,
                        input string tag);
    ev_t vw[$], sw[$], pc[$], mw[$], mr[$];
    ev_t evw[$], esw[$], epc[$], emw[$], emr[$];
    int lat, done_cyc, multi, busy_gap;
    logic [AW-1:0] base, a;
    logic [VW-1:0] asm_vec;

    base = res[AW-1:0];
    lat  = 1;
    case (ft)
      FT_VADD, FT_SMUL:        evw.push_back(ev_t'{1, AW'(v), res});
      FT_VDOT, FT_SLL, FT_SLH: esw.push_back(ev_t'{1, AW'(r), VW'(res[EW-1:0])});
      FT_J:                    epc.push_back(ev_t'{1, '0, VW'(res[AW-1:0])});
      FT_SST:                  emw.push_back(ev_t'{1, base, VW'(ss)});
      FT_VST: begin
        lat = ELEMS;
        for (int i = 0; i < ELEMS; i++) begin
          a = base + AW'(i);
          emw.push_back(ev_t'{i + 1, a, VW'(sv[EW*i +: EW])});
        end
      end
      FT_VLD: begin
        lat = ELEMS + 2;
        for (int i = 0; i < ELEMS; i++) begin
          a = base + AW'(i);
          emr.push_back(ev_t'{i + 1, a, '0});
          asm_vec[EW*i +: EW] = mem_val(a);
        end
        evw.push_back(ev_t'{ELEMS + 2, AW'(v), asm_vec});
      end
      default: ;
    endcase

    functype = ft; result = res; store_vec = sv; store_scalar = ss; vd = v; rd = r;
    start = 1'b1;
    step();
    start = 1'b0;
    scramble_inputs();

    done_cyc = 0; multi = 0; busy_gap = 0;
    for (int c = 1; c <= ELEMS + 6; c++) begin
      if ($countones(strobes()) > 1) multi++;
      if (!busy) busy_gap++;
      if (vwe)     vw.push_back(ev_t'{c, AW'(vwaddr), vwdata});
      if (swe)     sw.push_back(ev_t'{c, AW'(swaddr), VW'(swdata)});
      if (pc_load) pc.push_back(ev_t'{c, '0, VW'(pc_next)});
      if (mem_we)  mw.push_back(ev_t'{c, mem_addr, VW'(mem_wdata)});
      if (mem_re)  mr.push_back(ev_t'{c, mem_addr, '0});
      if (done) begin
        done_cyc = c;
        break;
      end
      step();
    end
    check({tag, " done latency"}, CKW'(done_cyc), CKW'(lat));
    check({tag, " cycles with >1 strobe"}, CKW'(multi), '0);
    check({tag, " cycles not busy before done"}, CKW'(busy_gap), '0);
    cmp_ev({tag, " vwrite"}, vw, evw);
    cmp_ev({tag, " swrite"}, sw, esw);
    cmp_ev({tag, " pcload"}, pc, epc);
    cmp_ev({tag, " memwrite"}, mw, emw);
    cmp_ev({tag, " memread"}, mr, emr);
    step();
    check({tag, " busy after done"}, CKW'(busy), '0);
    check({tag, " done after done"}, CKW'(done), '0);
  endtask

  vec_t tbl[9];
  logic [3:0] codes[12] = '{FT_VADD, FT_VDOT, FT_SMUL, FT_SST, FT_VLD, FT_VST,
                           FT_SLL, FT_SLH, FT_J, FT_NOP, 4'b1010, FT_VST};

  initial begin
    logic [VW-1:0] ramp, sv;
    ev_t got[$], exp[$];
    logic [AW-1:0] a;
    int done_cyc, stray, seen;
    string tag;

    rst = 1'b1; start = 1'b0; functype = '0; result = '0; store_vec = '0;
    store_scalar = '0; vd = '0; rd = '0;
    repeat (3) step();

    // Reset state
    check("reset busy", CKW'(busy), '0);
    check("reset done", CKW'(done), '0);
    check("reset strobes", CKW'(strobes()), '0);
    check("reset vwaddr/vwdata", {vwaddr, vwdata}, '0);
    check("reset swaddr/swdata/pc_next", {swaddr, swdata, pc_next}, '0);
    check("reset mem_addr/mem_wdata", {mem_addr, mem_wdata}, '0);
    rst = 1'b0;
    step();

    // ---------------- single-cycle op table ----------------
    for (int i = 0; i < ELEMS; i++) ramp[EW*i +: EW] = EW'(ELEMS - i);  // 0001_0002_..._0010
    tbl[0] = '{FT_VADD, ramp, 16'h0, 3'd5, 3'd0, 5'b10000, 3'd5, ramp, 16'h0};
    tbl[1] = '{FT_SMUL, {16{16'hDEAD}}, 16'h0, 3'd2, 3'd6, 5'b10000, 3'd2, {16{16'hDEAD}}, 16'h0};
    tbl[2] = '{FT_VDOT, {{15{16'hFFFF}}, 16'h1234}, 16'h0, 3'd1, 3'd3, 5'b01000, 3'd3, VW'(16'h1234), 16'h0};
    tbl[3] = '{FT_SLL, {{15{16'h7777}}, 16'hBEEF}, 16'h0, 3'd4, 3'd7, 5'b01000, 3'd7, VW'(16'hBEEF), 16'h0};
    tbl[4] = '{FT_SLH, {{15{16'h1111}}, 16'h0055}, 16'h0, 3'd6, 3'd0, 5'b01000, 3'd0, VW'(16'h0055), 16'h0};
    tbl[5] = '{FT_J, {{15{16'h5A5A}}, 16'h00F3}, 16'h0, 3'd3, 3'd2, 5'b00100, 3'd0, VW'(16'h00F3), 16'h0};
    tbl[6] = '{FT_SST, {{15{16'hFFFF}}, 16'h0100}, 16'hCAFE, 3'd0, 3'd0, 5'b00010, 3'd0, VW'(16'hCAFE), 16'h0100};
    tbl[7] = '{FT_NOP, {16{16'h3C3C}}, 16'h9999, 3'd7, 3'd7, 5'b00000, 3'd0, '0, 16'h0};
    tbl[8] = '{4'b1010, {16{16'hC3C3}}, 16'h8888, 3'd1, 3'd1, 5'b00000, 3'd0, '0, 16'h0};

    foreach (tbl[k]) begin
      tag = $sformatf("tbl%0d ft=%b", k, tbl[k].ft);
      functype = tbl[k].ft; result = tbl[k].res; store_scalar = tbl[k].ss;
      vd = tbl[k].vd; rd = tbl[k].rd; store_vec = rand_vec();
      start = 1'b1;
      step();
      start = 1'b0;
      scramble_inputs();
      check({tag, " strobes"}, CKW'(strobes()), CKW'(tbl[k].exp_stb));
      check({tag, " done"}, CKW'(done), 1);
      check({tag, " busy"}, CKW'(busy), 1);
      if (tbl[k].exp_stb[4]) check({tag, " vwaddr/vwdata"}, {vwaddr, vwdata}, {tbl[k].exp_waddr, tbl[k].exp_wdata});
      if (tbl[k].exp_stb[3]) check({tag, " swaddr/swdata"}, {swaddr, swdata}, {tbl[k].exp_waddr, tbl[k].exp_wdata[EW-1:0]});
      if (tbl[k].exp_stb[2]) check({tag, " pc_next"}, CKW'(pc_next), CKW'(tbl[k].exp_wdata[AW-1:0]));
      if (tbl[k].exp_stb[1]) check({tag, " mem_addr/mem_wdata"}, {mem_addr, mem_wdata}, {tbl[k].exp_addr, tbl[k].exp_wdata[EW-1:0]});
      step();
      check({tag, " idle after"}, {busy, done, strobes()}, '0);
    end

    // ---------------- VST wrapping 0xFFFE, with stray starts ----------------
    for (int i = 0; i < ELEMS; i++) sv[EW*i +: EW] = EW'(16'h1000 + i);
    functype = FT_VST; result = {{15{16'h4321}}, 16'hFFFE}; store_vec = sv;
    start = 1'b1;
    step();
    start = 1'b0;
    scramble_inputs();
    done_cyc = 0; stray = 0;
    for (int c = 1; c <= ELEMS + 4; c++) begin
      if (mem_we) got.push_back(ev_t'{c, mem_addr, VW'(mem_wdata)});
      if (pc_load || vwe || swe || mem_re) stray++;
      start = 1'b0;
      if (c == 3) begin
        functype = FT_J; result = VW'(16'h0BAD); start = 1'b1;
      end
      if (done) begin
        done_cyc = c;
        functype = FT_J; result = VW'(16'h0BAD); start = 1'b1;  // same cycle as done: dropped
        step();
        start = 1'b0;
        break;
      end
      step();
    end
    for (int i = 0; i < ELEMS; i++) begin
      a = 16'hFFFE + AW'(i);
      exp.push_back(ev_t'{i + 1, a, VW'(16'h1000 + i)});
    end
    check("vst_wrap done latency", CKW'(done_cyc), CKW'(ELEMS));
    check("vst_wrap stray strobes", CKW'(stray), '0);
    cmp_ev("vst_wrap memwrite", got, exp);
    check("vst_wrap done+1 idle", {busy, strobes()}, '0);
    functype = FT_J; result = {{15{16'hEEEE}}, 16'h0077};
    start = 1'b1;
    step();
    start = 1'b0;
    check("start at done+1 pc_load/done", {pc_load, done}, 2'b11);
    check("start at done+1 pc_next", CKW'(pc_next), CKW'(16'h0077));
    step();

    // ---------------- VLD at 0x0040 ----------------
    run_op(FT_VLD, {{15{16'h2222}}, 16'h0040}, rand_vec(), 16'h0, 3'd6, 3'd0, "vld_0040");

    // ---------------- reset in the middle of a VLD ----------------
    functype = FT_VLD; result = VW'(16'h0200); vd = 3'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();                       // now in cycle T+8
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort busy/done/strobes", {busy, done, strobes()}, '0);
    check("abort mem_addr/mem_wdata", {mem_addr, mem_wdata}, '0);
    check("abort vwaddr/vwdata", {vwaddr, vwdata}, '0);
    seen = 0;
    for (int c = 0; c < ELEMS + 6; c++) begin
      if (vwe || done || busy || mem_re) seen++;
      step();
    end
    check("abort later activity", CKW'(seen), '0);
    run_op(FT_SST, {{15{16'h0F0F}}, 16'h0321}, rand_vec(), 16'h5EED, 3'd0, 3'd0, "sst_after_abort");

    // ---------------- random instructions vs model ----------------
    for (int n = 0; n < 40; n++) begin
      logic [3:0] ft;
      logic [VW-1:0] res;
      ft  = codes[$urandom_range(0, 11)];
      res = rand_vec();
      if ($urandom_range(0, 2) == 0) res[AW-1:0] = 16'hFFF0 + 16'($urandom_range(0, 15));
      run_op(ft, res, rand_vec(), 16'($urandom), 3'($urandom), 3'($urandom),
             $sformatf("rnd%0d ft=%b", n, ft));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
